cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Hardwired control unit that drives the LD/INC/CLR inputs of the 6-bit program counter and 9-bit accumulator counters, plus the AR/DR/IR load strobes and memory read.
- Implements fetch/decode/execute for a 4-instruction ISA:
  - Instruction format: DR[7:6] is the opcode, DR[5:0] is the address.
  - Opcodes: 00 ADD, 01 AND, 10 JMP, 11 INC.
- The sequencer advances on posedge CLK. Its Moore control outputs are stable across the cycle, so the negedge-clocked datapath counters and registers sample them mid-cycle.

Parameters:
- ST_W, 4, width of the state register and the STATE debug output.
- OP_W, 2, opcode width taken from DR.

Ports:
- CLK  in  1  system clock; sequencer state updates on posedge.
- CLR  in  1  asynchronous, active-high reset.
- OPCODE  in  OP_W  DR[7:6] from the data register; valid from FETCH3 onward.
- MEM_RDY  in  1  memory read data valid this cycle.
- MEM_RD  out  1  memory read request.
- AR_LD  out  1  load address register.
- AR_SEL  out  1  AR source select: 0 = PC, 1 = DR[5:0].
- DR_LD  out  1  load data register from memory.
- IR_LD  out  1  load instruction register from DR.
- PC_LD  out  1  program counter LD (load DR[5:0]).
- PC_INC  out  1  program counter INC.
- PC_CLR  out  1  program counter CLR.
- AC_LD  out  1  accumulator LD (from ALU).
- AC_INC  out  1  accumulator INC.
- AC_CLR  out  1  accumulator CLR.
- ALU_OP  out  1  ALU select: 0 = ADD, 1 = AND.
- STATE  out  ST_W  current state encoding (debug).

Behaviour:
- Reset (CLR high, asynchronous):
  - State goes to INIT (0) immediately.
  - All control outputs are forced to 0 while CLR is high, regardless of state. STATE reads 0.
- State encodings and Moore outputs (all unlisted outputs are 0):
  - INIT = 0: PC_CLR, AC_CLR. Next state FETCH1.
  - FETCH1 = 1: AR_LD, AR_SEL = 0. Next state FETCH2.
  - FETCH2 = 2: MEM_RD. When MEM_RDY = 1, also DR_LD and PC_INC, and next state FETCH3. When MEM_RDY = 0, hold FETCH2.
  - FETCH3 = 3: IR_LD, AR_LD, AR_SEL = 1. Next state by OPCODE: 00 → ADD1, 01 → AND1, 10 → JMP1, 11 → INC1.
  - ADD1 = 4: MEM_RD. When MEM_RDY = 1, also DR_LD and next state ADD2; otherwise hold.
  - ADD2 = 5: AC_LD, ALU_OP = 0. Next state FETCH1.
  - AND1 = 6: MEM_RD. When MEM_RDY = 1, also DR_LD and next state AND2; otherwise hold.
  - AND2 = 7: AC_LD, ALU_OP = 1. Next state FETCH1.
  - JMP1 = 8: PC_LD. Next state FETCH1.
  - INC1 = 9: AC_INC. Next state FETCH1.
- Illegal encodings (10–15): all outputs 0; next state INIT.
- DR_LD and PC_INC in wait states are gated combinationally by MEM_RDY. MEM_RD stays high for the whole wait.
- Latency with zero wait states, in CLK cycles:
  - Fetch: 3.
  - ADD and AND: 5 total.
  - JMP and INC: 4 total.
  - Each MEM_RDY = 0 cycle in FETCH2, ADD1 or AND1 adds exactly 1 cycle.
- At most one of PC_LD, PC_INC, PC_CLR is high in any cycle. The same holds for AC_LD, AC_INC, AC_CLR.
- PC wrap (63 → 0) and AC overflow are owned by the counters; the sequencer takes no action.
- CLR asserted mid-instruction: the instruction is abandoned. After CLR deasserts, the sequencer executes INIT for 1 cycle, then FETCH1.
- OPCODE is sampled only at the posedge that leaves FETCH3. Changes in any other state are ignored.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Adds input port STEP (1 bit) and a registered copy of STEP for rising-edge detection.
  - FETCH1 holds, with AR_LD still asserted, until a STEP rising edge is detected. Exactly one instruction executes per STEP rising edge.
  - STEP held high does not execute further instructions.
  - CLR clears the edge-detect register to 0.
- When undefined: no STEP port and no extra flop; FETCH1 always advances.

Test Plan:
- Reset and INIT: assert CLR mid-cycle → all outputs 0 and STATE = 0 immediately. Release CLR → one cycle with PC_CLR = AC_CLR = 1, then STATE = 1 with AR_LD = 1, AR_SEL = 0.
- ADD with MEM_RDY tied 1 and OPCODE = 00:
  - STATE sequence 0,1,2,3,4,5,1.
  - AC_LD = 1 with ALU_OP = 0 only in state 5.
  - PC_INC pulses exactly once, in state 2.
- Wait states: MEM_RDY = 0 for 3 cycles in FETCH2 → STATE holds at 2 for 4 cycles, MEM_RD = 1 throughout, DR_LD and PC_INC high only in the final cycle.
- JMP (OPCODE = 10) → PC_LD = 1 for exactly 1 cycle in state 8, then state 1. INC (OPCODE = 11) → AC_INC = 1 in state 9 only.
- Reset mid-operation: assert CLR while in ADD1 with MEM_RDY = 0 → STATE = 0 and MEM_RD = 0 immediately. After release, the sequence is INIT, then FETCH1.
- SINGLE_STEP_EN defined: with STEP held 0, the sequencer stays in state 1 for 10 cycles. One STEP pulse runs exactly one INC instruction and returns to state 1. STEP held high for 20 cycles runs only one instruction.

Source files
------------

// File: rtl/cpu_control_sequencer_if.sv
// Control bus between the hardwired sequencer and the PC/AC/AR/DR/IR datapath.
// master = sequencer side, slave = datapath side.
interface cpu_control_sequencer_if #(
  parameter int OP_W = 2,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] OPCODE;
  logic            MEM_RDY;
  logic            MEM_RD;
  logic            AR_LD;
  logic            AR_SEL;
  logic            DR_LD;
  logic            IR_LD;
  logic            PC_LD;
  logic            PC_INC;
  logic            PC_CLR;
  logic            AC_LD;
  logic            AC_INC;
  logic            AC_CLR;
  logic            ALU_OP;
  logic [ST_W-1:0] STATE;

  modport master (
    input  OPCODE, MEM_RDY,
    output MEM_RD, AR_LD, AR_SEL, DR_LD,
    output IR_LD, PC_LD, PC_INC, PC_CLR,
    output AC_LD, AC_INC, AC_CLR, ALU_OP,
    output STATE
  );

  modport slave (
    output OPCODE, MEM_RDY,
    input  MEM_RD, AR_LD, AR_SEL, DR_LD,
    input  IR_LD, PC_LD, PC_INC, PC_CLR,
    input  AC_LD, AC_INC, AC_CLR, ALU_OP,
    input  STATE
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 4-op accumulator CPU.
// Optional SINGLE_STEP_EN: FETCH1 waits for a rising edge on STEP.
module cpu_control_sequencer #(
  parameter int ST_W = 4,
  parameter int OP_W = 2
) (
  input  logic CLK,
  input  logic CLR,
`ifdef SINGLE_STEP_EN
  input  logic STEP,
`endif
  cpu_control_sequencer_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    S_INIT   = ST_W'(0),
    S_FETCH1 = ST_W'(1),
    S_FETCH2 = ST_W'(2),
    S_FETCH3 = ST_W'(3),
    S_ADD1   = ST_W'(4),
    S_ADD2   = ST_W'(5),
    S_AND1   = ST_W'(6),
    S_AND2   = ST_W'(7),
    S_JMP1   = ST_W'(8),
    S_INC1   = ST_W'(9)
  } state_t;

  typedef struct packed {
    logic mem_rd;
    logic ar_ld;
    logic ar_sel;
    logic dr_ld;
    logic ir_ld;
    logic pc_ld;
    logic pc_inc;
    logic pc_clr;
    logic ac_ld;
    logic ac_inc;
    logic ac_clr;
    logic alu_op;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl;
  ctl_t   ctl_o;
  logic   go;

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) step_q <= 1'b0;
    else     step_q <= STEP;
  end

  assign go = STEP & ~step_q;
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= S_INIT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    ctl = '0;
    case (state)
      S_INIT: begin
        ctl.pc_clr = 1'b1;
        ctl.ac_clr = 1'b1;
        nxt        = S_FETCH1;
      end
      S_FETCH1: begin
        ctl.ar_ld = 1'b1;
        if (go) nxt = S_FETCH2;
      end
      S_FETCH2: begin
        ctl.mem_rd = 1'b1;
        ctl.dr_ld  = bus.MEM_RDY;
        ctl.pc_inc = bus.MEM_RDY;
        if (bus.MEM_RDY) nxt = S_FETCH3;
      end
      S_FETCH3: begin
        ctl.ir_ld  = 1'b1;
        ctl.ar_ld  = 1'b1;
        ctl.ar_sel = 1'b1;
        unique case (1'b1)
          (bus.OPCODE == OP_W'(0)): nxt = S_ADD1;
          (bus.OPCODE == OP_W'(1)): nxt = S_AND1;
          (bus.OPCODE == OP_W'(2)): nxt = S_JMP1;
          default:                  nxt = S_INC1;
        endcase
      end
      S_ADD1: begin
        ctl.mem_rd = 1'b1;
        ctl.dr_ld  = bus.MEM_RDY;
        if (bus.MEM_RDY) nxt = S_ADD2;
      end
      S_ADD2: begin
        ctl.ac_ld = 1'b1;
        nxt       = S_FETCH1;
      end
      S_AND1: begin
        ctl.mem_rd = 1'b1;
        ctl.dr_ld  = bus.MEM_RDY;
        if (bus.MEM_RDY) nxt = S_AND2;
      end
      S_AND2: begin
        ctl.ac_ld  = 1'b1;
        ctl.alu_op = 1'b1;
        nxt        = S_FETCH1;
      end
      S_JMP1: begin
        ctl.pc_ld = 1'b1;
        nxt       = S_FETCH1;
      end
      S_INC1: begin
        ctl.ac_inc = 1'b1;
        nxt        = S_FETCH1;
      end
      default: nxt = S_INIT;
    endcase
  end

  // Reset must silence the datapath immediately, not at the next edge.
  assign ctl_o = CLR ? '0 : ctl;

  assign bus.MEM_RD = ctl_o.mem_rd;
  assign bus.AR_LD  = ctl_o.ar_ld;
  assign bus.AR_SEL = ctl_o.ar_sel;
  assign bus.DR_LD  = ctl_o.dr_ld;
  assign bus.IR_LD  = ctl_o.ir_ld;
  assign bus.PC_LD  = ctl_o.pc_ld;
  assign bus.PC_INC = ctl_o.pc_inc;
  assign bus.PC_CLR = ctl_o.pc_clr;
  assign bus.AC_LD  = ctl_o.ac_ld;
  assign bus.AC_INC = ctl_o.ac_inc;
  assign bus.AC_CLR = ctl_o.ac_clr;
  assign bus.ALU_OP = ctl_o.alu_op;
  assign bus.STATE  = state;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Table-driven, scoreboarded bench for cpu_control_sequencer.
// Output vector: MEM_RD AR_LD AR_SEL DR_LD IR_LD PC_LD PC_INC PC_CLR AC_LD AC_INC AC_CLR ALU_OP.
module tb_cpu_control_sequencer;

  localparam logic [11:0] O_NONE = 12'h000;
  localparam logic [11:0] O_INIT = 12'h012;
  localparam logic [11:0] O_F1   = 12'h400;
  localparam logic [11:0] O_RDW  = 12'h800;
  localparam logic [11:0] O_F2   = 12'h920;
  localparam logic [11:0] O_F3   = 12'h680;
  localparam logic [11:0] O_X1   = 12'h900;
  localparam logic [11:0] O_ADD2 = 12'h008;
  localparam logic [11:0] O_AND2 = 12'h009;
  localparam logic [11:0] O_JMP  = 12'h040;
  localparam logic [11:0] O_INC  = 12'h004;

  typedef struct {
    logic        rdy;
    logic [1:0]  op;
    logic [3:0]  st;
    logic [11:0] outs;
  } vec_t;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
`ifdef SINGLE_STEP_EN
  logic step_in = 1'b0;
`endif

  cpu_control_sequencer_if bus ();

  cpu_control_sequencer dut (
    .CLK  (CLK),
    .CLR  (CLR),
`ifdef SINGLE_STEP_EN
    .STEP (step_in),
`endif
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  logic [11:0] obs;
  assign obs = {bus.MEM_RD, bus.AR_LD, bus.AR_SEL, bus.DR_LD,
                bus.IR_LD, bus.PC_LD, bus.PC_INC, bus.PC_CLR,
                bus.AC_LD, bus.AC_INC, bus.AC_CLR, bus.ALU_OP};

  vec_t sbq[$];
  vec_t tbl1[$];
  vec_t tbl2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;

  function automatic vec_t mk(input logic rdy, input logic [1:0] op,
                              input logic [3:0] st, input logic [11:0] outs);
    vec_t v;
    v.rdy = rdy; v.op = op; v.st = st; v.outs = outs;
    return v;
  endfunction

  task automatic check(input string tag);
    vec_t e;
    e = sbq.pop_front();
    n_cmp++;
    if (bus.STATE !== e.st || obs !== e.outs) begin
      n_bad++;
      $display("FAIL %s row %0d: got state=%0d outs=%03h, want state=%0d outs=%03h",
               tag, row, bus.STATE, obs, e.st, e.outs);
    end
    row++;
  endtask

  // Called at posedge+1; checks mid-cycle, returns at next posedge+1.
  task automatic apply_raw(input logic rdy, input logic [1:0] op, input logic stp,
                           input logic [3:0] st, input logic [11:0] outs,
                           input string tag);
    bus.MEM_RDY = rdy;
    bus.OPCODE  = op;
`ifdef SINGLE_STEP_EN
    step_in = stp;
`else
    if (stp) begin end
`endif
    sbq.push_back(mk(rdy, op, st, outs));
    @(negedge CLK);
    check(tag);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    apply_raw(v.rdy, v.op, (v.st == 4'd1), v.st, v.outs, tag);
  endtask

  initial begin
    // ADD, wait states, JMP, INC, AND; OPCODE wiggles outside FETCH3.
    tbl1.push_back(mk(1, 2'b11, 4'd0, O_INIT));
    tbl1.push_back(mk(1, 2'b10, 4'd1, O_F1));
    tbl1.push_back(mk(1, 2'b01, 4'd2, O_F2));
    tbl1.push_back(mk(1, 2'b00, 4'd3, O_F3));
    tbl1.push_back(mk(1, 2'b10, 4'd4, O_X1));
    tbl1.push_back(mk(1, 2'b11, 4'd5, O_ADD2));
    tbl1.push_back(mk(1, 2'b01, 4'd1, O_F1));
    tbl1.push_back(mk(0, 2'b00, 4'd2, O_RDW));
    tbl1.push_back(mk(0, 2'b01, 4'd2, O_RDW));
    tbl1.push_back(mk(0, 2'b11, 4'd2, O_RDW));
    tbl1.push_back(mk(1, 2'b00, 4'd2, O_F2));
    tbl1.push_back(mk(1, 2'b10, 4'd3, O_F3));
    tbl1.push_back(mk(1, 2'b00, 4'd8, O_JMP));
    tbl1.push_back(mk(1, 2'b00, 4'd1, O_F1));
    tbl1.push_back(mk(1, 2'b00, 4'd2, O_F2));
    tbl1.push_back(mk(1, 2'b11, 4'd3, O_F3));
    tbl1.push_back(mk(1, 2'b00, 4'd9, O_INC));
    tbl1.push_back(mk(1, 2'b00, 4'd1, O_F1));
    tbl1.push_back(mk(1, 2'b10, 4'd2, O_F2));
    tbl1.push_back(mk(1, 2'b01, 4'd3, O_F3));
    tbl1.push_back(mk(0, 2'b10, 4'd6, O_RDW));
    tbl1.push_back(mk(1, 2'b10, 4'd6, O_X1));
    tbl1.push_back(mk(1, 2'b00, 4'd7, O_AND2));
    tbl1.push_back(mk(1, 2'b00, 4'd1, O_F1));
    tbl1.push_back(mk(1, 2'b00, 4'd2, O_F2));
    tbl1.push_back(mk(1, 2'b00, 4'd3, O_F3));
    tbl1.push_back(mk(0, 2'b00, 4'd4, O_RDW));
    // After mid-op reset: INIT, FETCH1, then an INC instruction.
    tbl2.push_back(mk(0, 2'b00, 4'd0, O_INIT));
    tbl2.push_back(mk(1, 2'b00, 4'd1, O_F1));
    tbl2.push_back(mk(1, 2'b00, 4'd2, O_F2));
    tbl2.push_back(mk(1, 2'b11, 4'd3, O_F3));
    tbl2.push_back(mk(1, 2'b00, 4'd9, O_INC));

    bus.MEM_RDY = 1'b1;
    bus.OPCODE  = 2'b00;
    #2;
    apply_raw(1, 2'b00, 0, 4'd0, O_NONE, "reset_hold");
    apply_raw(1, 2'b00, 0, 4'd0, O_NONE, "reset_hold");
    CLR = 1'b0;

    foreach (tbl1[i]) apply(tbl1[i], "seq");

    // Still in ADD1 waiting on memory: reset must kill MEM_RD at once.
    bus.MEM_RDY = 1'b0;
    #2;
    CLR = 1'b1;
    #1;
    sbq.push_back(mk(0, 2'b00, 4'd0, O_NONE));
    check("midop_reset");
    @(posedge CLK);
    #1;
    CLR = 1'b0;

    foreach (tbl2[i]) apply(tbl2[i], "post_reset");

`ifdef SINGLE_STEP_EN
    for (int i = 0; i < 10; i++)
      apply_raw(1, 2'b11, 0, 4'd1, O_F1, "step_idle");
    apply_raw(1, 2'b11, 1, 4'd1, O_F1, "step_pulse");
    apply_raw(1, 2'b11, 0, 4'd2, O_F2, "step_pulse");
    apply_raw(1, 2'b11, 0, 4'd3, O_F3, "step_pulse");
    apply_raw(1, 2'b11, 0, 4'd9, O_INC, "step_pulse");
    apply_raw(1, 2'b11, 0, 4'd1, O_F1, "step_pulse");
    apply_raw(1, 2'b11, 0, 4'd1, O_F1, "step_pulse");
    begin
      int n_inc = 0;
      step_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (bus.STATE == 4'd9) n_inc++;
        @(posedge CLK);
        #1;
      end
      n_cmp++;
      if (n_inc != 1) begin
        n_bad++;
        $display("FAIL step_held: got %0d INC cycles, want 1", n_inc);
      end
      apply_raw(1, 2'b11, 1, 4'd1, O_F1, "step_held_end");
    end
`else
    apply_raw(1, 2'b00, 1, 4'd1, O_F1, "post_reset");
    apply_raw(1, 2'b00, 0, 4'd2, O_F2, "post_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
